// File: rtl/dm_cache_fsm.sv
// Direct-mapped write-back/write-allocate cache controller: computes the replacement
// line and memory strobes from the indexed line and the current CPU request.
package cache_pkg;
  typedef enum logic [1:0] {
    CS_INVALID,
    CS_SHARED,
    CS_EXCLUSIVE,
    CS_MODIFIED
  } coh_state_e;

  typedef struct packed {
    logic        valid;
    logic        dirty;
    logic [23:0] tag;
    logic [127:0] block;
    coh_state_e  state;
  } cacheLine;
endpackage

module dm_cache_fsm (
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic               valid,
  input  logic [1:0]         offset,
  input  logic [23:0]        addrTag,
  input  logic [31:0]        write_word,
  input  cache_pkg::cacheLine oldCL,
  input  logic [127:0]       data_in,
  output logic [127:0]       data_out,
  output logic [31:0]        read_word,
  output cache_pkg::cacheLine newCL,
  output logic               ready,
  output logic               write_to_mem,
  output logic               read_from_mem
);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  state_e state_q, state_d;

  logic         hit;
  logic [31:0]  sel_word;
  logic [127:0] merged_block;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Offset 0 addresses the most significant word of the block.
  always_comb begin
    hit          = oldCL.valid && (oldCL.tag == addrTag);
    sel_word     = '0;
    merged_block = oldCL.block;
    case (offset)
      2'd0: begin
        sel_word              = oldCL.block[127:96];
        merged_block[127:96]  = write_word;
      end
      2'd1: begin
        sel_word              = oldCL.block[95:64];
        merged_block[95:64]   = write_word;
      end
      2'd2: begin
        sel_word              = oldCL.block[63:32];
        merged_block[63:32]   = write_word;
      end
      default: begin
        sel_word              = oldCL.block[31:0];
        merged_block[31:0]    = write_word;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    newCL         = oldCL;
    ready         = 1'b0;
    write_to_mem  = 1'b0;
    read_from_mem = 1'b0;
    data_out      = '0;
    read_word     = '0;

    case (state_q)
      IDLE: begin
        ready = !valid;
        if (valid) begin
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (hit) begin
          state_d = IDLE;
          // Read takes priority so a simultaneous read/write leaves the line untouched.
          if (read) begin
            read_word = sel_word;
          end else if (write) begin
            newCL.block = merged_block;
            newCL.dirty = 1'b1;
            newCL.valid = 1'b1;
          end
        end else begin
          newCL.tag = addrTag;
          state_d   = oldCL.dirty ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        write_to_mem = 1'b1;
        data_out     = oldCL.block;
        state_d      = ALLOCATE;
      end

      ALLOCATE: begin
        read_from_mem = 1'b1;
        newCL.block   = data_in;
        newCL.valid   = 1'b1;
        newCL.dirty   = 1'b0;
        state_d       = COMPARE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_cache_fsm.sv
// Directed bench for dm_cache_fsm; models the parent array as a row register
// that captures newCL on every rising edge unless the bench preloads it.
module tb_dm_cache_fsm;
  import cache_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         read, write, valid;
  logic [1:0]   offset;
  logic [23:0]  addrTag;
  logic [31:0]  write_word;
  cacheLine     row;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic [31:0]  read_word;
  cacheLine     newCL;
  logic         ready, write_to_mem, read_from_mem;

  logic         load_en;
  cacheLine     load_val;

  int n_vec = 0;
  int n_err = 0;

  dm_cache_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .valid         (valid),
    .offset        (offset),
    .addrTag       (addrTag),
    .write_word    (write_word),
    .oldCL         (row),
    .data_in       (data_in),
    .data_out      (data_out),
    .read_word     (read_word),
    .newCL         (newCL),
    .ready         (ready),
    .write_to_mem  (write_to_mem),
    .read_from_mem (read_from_mem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) row <= load_val;
    else         row <= newCL;
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cacheLine mkline(input logic v, input logic d, input logic [23:0] t,
                                      input logic [127:0] b, input coh_state_e s);
    cacheLine c;
    c.valid = v;
    c.dirty = d;
    c.tag   = t;
    c.block = b;
    c.state = s;
    return c;
  endfunction

  task automatic preload(input cacheLine c);
    load_en  = 1'b1;
    load_val = c;
    tick();
    load_en  = 1'b0;
  endtask

  localparam logic [127:0] BLK_A  = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK_A5 = {4{32'hA5A5A5A5}};
  localparam logic [127:0] BLK_OLD = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
  localparam logic [127:0] BLK_D  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  cacheLine exp_line;

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; valid = 1'b0;
    offset = '0; addrTag = '0; write_word = '0; data_in = '0;
    load_en = 1'b1;
    load_val = mkline(1'b1, 1'b0, 24'h00ABCD, BLK_A, CS_SHARED);
    #1;

    // Reset state
    tick();
    chk("rst_ready", 160'(ready), 160'd1);
    chk("rst_wr_mem", 160'(write_to_mem), 160'd0);
    chk("rst_rd_mem", 160'(read_from_mem), 160'd0);
    chk("rst_rdword", 160'(read_word), 160'd0);
    chk("rst_dout", 160'(data_out), 160'd0);
    chk("rst_newcl", 160'(newCL), 160'(mkline(1'b1, 1'b0, 24'h00ABCD, BLK_A, CS_SHARED)));
    valid = 1'b1;
    #1;
    chk("rst_ready_valid", 160'(ready), 160'd0);
    valid = 1'b0;
    reset = 1'b1;
    load_en = 1'b0;
    tick();

    // Read hit, offset 2
    preload(mkline(1'b1, 1'b0, 24'h00ABCD, BLK_A, CS_SHARED));
    read = 1'b1; offset = 2'd2; addrTag = 24'h00ABCD; valid = 1'b1;
    #1;
    chk("rh_c0_ready", 160'(ready), 160'd0);
    tick();
    valid = 1'b0;
    chk("rh_c1_word", 160'(read_word), 160'h33333333);
    chk("rh_c1_ready", 160'(ready), 160'd0);
    chk("rh_c1_line", 160'(newCL), 160'(mkline(1'b1, 1'b0, 24'h00ABCD, BLK_A, CS_SHARED)));
    tick();
    chk("rh_c2_ready", 160'(ready), 160'd1);
    chk("rh_c2_word", 160'(read_word), 160'd0);

    // Read and write both asserted on a hit: read wins, line unchanged
    read = 1'b1; write = 1'b1; offset = 2'd1; write_word = 32'h12345678; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("rw_word", 160'(read_word), 160'h22222222);
    chk("rw_line", 160'(newCL), 160'(mkline(1'b1, 1'b0, 24'h00ABCD, BLK_A, CS_SHARED)));
    tick();

    // Write hit, offset 0
    read = 1'b0; write = 1'b1; offset = 2'd0; write_word = 32'hDEADBEEF; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("wh_line", 160'(newCL), 160'(mkline(1'b1, 1'b1, 24'h00ABCD,
        128'hDEADBEEF_22222222_33333333_44444444, CS_SHARED)));
    chk("wh_rdword", 160'(read_word), 160'd0);
    tick();
    chk("wh_ready", 160'(ready), 160'd1);

    // Clean read miss (invalid line), offset 3
    preload(mkline(1'b0, 1'b0, 24'h000777, BLK_A, CS_INVALID));
    read = 1'b1; write = 1'b0; offset = 2'd3; addrTag = 24'h123456;
    data_in = BLK_A5; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("cm_c1_tag", 160'(newCL.tag), 160'h123456);
    chk("cm_c1_rd_mem", 160'(read_from_mem), 160'd0);
    chk("cm_c1_rdword", 160'(read_word), 160'd0);
    tick();
    chk("cm_c2_rd_mem", 160'(read_from_mem), 160'd1);
    chk("cm_c2_wr_mem", 160'(write_to_mem), 160'd0);
    chk("cm_c2_line", 160'(newCL), 160'(mkline(1'b1, 1'b0, 24'h123456, BLK_A5, CS_INVALID)));
    chk("cm_c2_ready", 160'(ready), 160'd0);
    tick();
    chk("cm_c3_word", 160'(read_word), 160'hA5A5A5A5);
    chk("cm_c3_rd_mem", 160'(read_from_mem), 160'd0);
    chk("cm_c3_ready", 160'(ready), 160'd0);
    tick();
    chk("cm_c4_ready", 160'(ready), 160'd1);

    // Dirty write miss, offset 1
    preload(mkline(1'b1, 1'b1, 24'h111111, BLK_OLD, CS_MODIFIED));
    read = 1'b0; write = 1'b1; offset = 2'd1; addrTag = 24'h222222;
    write_word = 32'hCAFEF00D; data_in = BLK_D; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("dm_c1_tag", 160'(newCL.tag), 160'h222222);
    chk("dm_c1_wr_mem", 160'(write_to_mem), 160'd0);
    tick();
    chk("dm_c2_wr_mem", 160'(write_to_mem), 160'd1);
    chk("dm_c2_rd_mem", 160'(read_from_mem), 160'd0);
    chk("dm_c2_dout", 160'(data_out), 160'(BLK_OLD));
    tick();
    chk("dm_c3_wr_mem", 160'(write_to_mem), 160'd0);
    chk("dm_c3_rd_mem", 160'(read_from_mem), 160'd1);
    chk("dm_c3_dout", 160'(data_out), 160'd0);
    chk("dm_c3_line", 160'(newCL), 160'(mkline(1'b1, 1'b0, 24'h222222, BLK_D, CS_MODIFIED)));
    tick();
    exp_line = mkline(1'b1, 1'b1, 24'h222222,
                      128'h01234567_CAFEF00D_FEDCBA98_76543210, CS_MODIFIED);
    chk("dm_c4_line", 160'(newCL), 160'(exp_line));
    chk("dm_c4_rd_mem", 160'(read_from_mem), 160'd0);
    chk("dm_c4_ready", 160'(ready), 160'd0);
    tick();
    chk("dm_c5_ready", 160'(ready), 160'd1);

    // Reset asserted during WRITEBACK
    preload(mkline(1'b1, 1'b1, 24'h333333, BLK_OLD, CS_MODIFIED));
    read = 1'b1; write = 1'b0; addrTag = 24'h444444; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    chk("ra_wb_wr_mem", 160'(write_to_mem), 160'd1);
    reset = 1'b0;
    #1;
    chk("ra_wr_mem_drop", 160'(write_to_mem), 160'd0);
    chk("ra_ready", 160'(ready), 160'd1);
    chk("ra_newcl", 160'(newCL), 160'(mkline(1'b1, 1'b1, 24'h444444, BLK_OLD, CS_MODIFIED)));
    tick();
    chk("ra_no_alloc", 160'(read_from_mem), 160'd0);
    reset = 1'b1;
    tick();
    chk("ra_post_rd_mem", 160'(read_from_mem), 160'd0);
    chk("ra_post_wr_mem", 160'(write_to_mem), 160'd0);
    chk("ra_post_ready", 160'(ready), 160'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
